// File: rtl/bcd_display_controller.sv
// bcd_display_controller: multi-cycle double-dabble binary-to-BCD converter with
// saturation, leading-zero blanking and outputs that change only on commit.
module bcd_display_controller #(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    value,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank
);
  localparam int BW = 4*NUM_DIGITS;
  localparam int CW = $clog2(BIN_WIDTH+1);
  localparam int MAX_I = 10**NUM_DIGITS - 1;
  localparam logic [BIN_WIDTH:0] MAX_V = MAX_I[BIN_WIDTH:0];
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                r_state, w_next;
  logic [BIN_WIDTH-1:0]  r_bin;
  logic [BW-1:0]         r_bcd, w_adj;
  logic [CW-1:0]         r_cnt;
  logic                  r_ovf;
  logic                  w_sat, w_last, w_accept;
  logic [NUM_DIGITS-1:0] w_blank;

  // compare one bit wider than the input so the limit never wraps
  assign w_sat    = {1'b0, value} > MAX_V;
  assign w_last   = r_cnt == CW'(BIN_WIDTH-1);
  assign w_accept = (r_state == IDLE) && start;
  assign busy     = r_state != IDLE;

  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_dig
      assign w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
      if (i == 0) begin : g_lsd
        assign w_blank[i] = 1'b0;
      end else begin : g_hi
        assign w_blank[i] = r_bcd[BW-1:4*i] == '0;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;

  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)  ? (start ? SHIFT : IDLE) :
             (r_state == SHIFT) ? (w_last ? COMMIT : SHIFT) : IDLE;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      digits   <= '0;
      blank    <= BLANK_RST;
    end else begin
      done <= r_state == COMMIT;
      if (w_accept) begin
        r_bin <= w_sat ? MAX_V[BIN_WIDTH-1:0] : value;
        r_bcd <= '0;
        r_cnt <= '0;
        r_ovf <= w_sat;
      end else if (r_state == SHIFT) begin
        {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
        r_cnt          <= r_cnt + CW'(1);
      end else if (r_state == COMMIT) begin
        digits   <= r_bcd;
        blank    <= w_blank;
        overflow <= r_ovf;
      end
    end
endmodule
